// File: rtl/buzzer_sched.sv
// buzzer_sched: fixed-priority play-request scheduler driving a single buzzer player.
module buzzer_sched #(
    parameter int NUM_REQ         = 3,
    parameter int GAP_CYCLES      = 5_000_000,
    parameter int MAX_PLAY_CYCLES = 500_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mute,
    input  logic               play_done,
    output logic               play_en,
    output logic               player_rst,
    output logic [NUM_REQ-1:0] track_sel,
    output logic               play_start,
    output logic               busy,
    output logic [1:0]         cur_track,
    output logic               timeout,
    output logic [7:0]         preempt_cnt
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int WW = MAX_PLAY_CYCLES > 1 ? $clog2(MAX_PLAY_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(MAX_PLAY_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, PLAY, ABORT, GAP} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] pend_nxt;
    logic [GW-1:0]      gap_cnt;
    logic [WW-1:0]      wd_cnt;
    logic [1:0]         gnt_idx;
    logic               hi_pend;
    logic               grant;

    always_comb begin
        gnt_idx = '0;
        hi_pend = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i]) gnt_idx = 2'(i);
            if (pend[i] && 2'(i) > cur_track) hi_pend = 1'b1;
        end
        grant    = !mute && |pend && (state == IDLE || state == ABORT);
        clr      = grant ? NUM_REQ'(1) << gnt_idx : '0;
        // a new request on the bit being granted survives the clear
        pend_nxt = mute ? '0 : (pend & ~clr) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            cur_track   <= '0;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            preempt_cnt <= '0;
            timeout     <= 1'b0;
        end else begin
            pend    <= pend_nxt;
            timeout <= 1'b0;
            case (state)
                IDLE, ABORT: begin
                    state <= grant ? START : IDLE;
                    if (grant) cur_track <= gnt_idx;
                end
                START: begin
                    state  <= PLAY;
                    wd_cnt <= '0;
                end
                PLAY: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (mute) state <= GAP;
                    else if (hi_pend) begin
                        state       <= ABORT;
                        preempt_cnt <= preempt_cnt + {7'd0, preempt_cnt != 8'hff};
                    end else if (play_done) state <= GAP;
                    else if (wd_cnt == WD_LAST) begin
                        state   <= GAP;
                        timeout <= 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt == GAP_LAST ? '0 : gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        play_en    = state == PLAY;
        player_rst = state == IDLE || state == GAP || state == ABORT;
        track_sel  = (state == START || state == PLAY) ? NUM_REQ'(1) << cur_track : '0;
        play_start = state == START;
        busy       = state != IDLE;
    end
endmodule

// File: tb/tb_buzzer_sched.sv
// tb_buzzer_sched: directed scenario tests for buzzer_sched with a 4-cycle gap and 20-cycle watchdog.
module tb_buzzer_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mute = 1'b0;
    logic       play_done = 1'b0;
    logic [2:0] req = 3'b000;
    logic       play_en, player_rst, play_start, busy, timeout;
    logic [2:0] track_sel;
    logic [1:0] cur_track;
    logic [7:0] preempt_cnt;
    logic [6:0] o;
    int checks = 0;
    int fails  = 0;

    localparam logic [6:0] O_IDLE = 7'b0100_000;
    localparam logic [6:0] O_GAP  = 7'b0101_000;

    always #5 clk = ~clk;

    // {play_en, player_rst, play_start, busy, track_sel}
    assign o = {play_en, player_rst, play_start, busy, track_sel};

    buzzer_sched #(.NUM_REQ(3), .GAP_CYCLES(4), .MAX_PLAY_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .req(req), .mute(mute), .play_done(play_done),
        .play_en(play_en), .player_rst(player_rst), .track_sel(track_sel),
        .play_start(play_start), .busy(busy), .cur_track(cur_track),
        .timeout(timeout), .preempt_cnt(preempt_cnt)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", o, O_IDLE); end
        checks++; if ({cur_track, preempt_cnt, timeout} !== 11'd0) begin fails++; $display("FAIL reset_regs got=%0d/%0d/%0b exp=0/0/0", cur_track, preempt_cnt, timeout); end
    endtask

    task automatic test_single;
        req = 3'b001; tick; req = 3'b000;
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL single_k1 got=%b exp=%b", o, O_IDLE); end
        tick;
        checks++; if (o !== 7'b0011_001) begin fails++; $display("FAIL single_start got=%b exp=0011001", o); end
        checks++; if (cur_track !== 2'd0) begin fails++; $display("FAIL single_track got=%0d exp=0", cur_track); end
        tick;
        checks++; if (o !== 7'b1001_001) begin fails++; $display("FAIL single_play got=%b exp=1001001", o); end
        tick(3);
        play_done = 1'b1; tick; play_done = 1'b0;
        checks++; if (o !== O_GAP) begin fails++; $display("FAIL single_gap got=%b exp=%b", o, O_GAP); end
        tick(3);
        checks++; if (o !== O_GAP) begin fails++; $display("FAIL single_gap_end got=%b exp=%b", o, O_GAP); end
        tick;
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL single_idle got=%b exp=%b", o, O_IDLE); end
    endtask

    task automatic test_priority;
        req = 3'b101; tick; req = 3'b000; tick;
        checks++; if (o !== 7'b0011_100 || cur_track !== 2'd2) begin fails++; $display("FAIL prio_first got=%b trk=%0d exp=0011100 trk=2", o, cur_track); end
        tick;
        play_done = 1'b1; tick; play_done = 1'b0;
        tick(4);
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL prio_idle got=%b exp=%b", o, O_IDLE); end
        tick;
        checks++; if (o !== 7'b0011_001 || cur_track !== 2'd0) begin fails++; $display("FAIL prio_second got=%b trk=%0d exp=0011001 trk=0", o, cur_track); end
        tick;
        play_done = 1'b1; tick; play_done = 1'b0;
        tick(4);
        checks++; if (o !== O_IDLE || preempt_cnt !== 8'd0) begin fails++; $display("FAIL prio_end got=%b pc=%0d exp=%b pc=0", o, preempt_cnt, O_IDLE); end
    endtask

    task automatic test_preempt;
        req = 3'b001; tick; req = 3'b000; tick(4);
        req = 3'b100; tick; req = 3'b000;
        checks++; if (o !== 7'b1001_001) begin fails++; $display("FAIL pre_still_play got=%b exp=1001001", o); end
        tick;
        checks++; if (o !== O_GAP || preempt_cnt !== 8'd1) begin fails++; $display("FAIL pre_abort got=%b pc=%0d exp=%b pc=1", o, preempt_cnt, O_GAP); end
        tick;
        checks++; if (o !== 7'b0011_100) begin fails++; $display("FAIL pre_start got=%b exp=0011100", o); end
        tick;
        play_done = 1'b1; tick; play_done = 1'b0;
        tick(4);
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL pre_idle got=%b exp=%b", o, O_IDLE); end
        tick(6);
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL pre_no_replay got=%b exp=%b", o, O_IDLE); end
    endtask

    task automatic test_no_preempt;
        req = 3'b100; tick; req = 3'b000; tick(2);
        req = 3'b010; tick; req = 3'b100; tick; req = 3'b000; tick;
        checks++; if (o !== 7'b1001_100) begin fails++; $display("FAIL nopre_play got=%b exp=1001100", o); end
        play_done = 1'b1; tick; play_done = 1'b0;
        tick(5);
        checks++; if (o !== 7'b0011_100 || cur_track !== 2'd2) begin fails++; $display("FAIL nopre_replay got=%b trk=%0d exp=0011100 trk=2", o, cur_track); end
        tick;
        play_done = 1'b1; tick; play_done = 1'b0;
        tick(5);
        checks++; if (o !== 7'b0011_010 || cur_track !== 2'd1) begin fails++; $display("FAIL nopre_low got=%b trk=%0d exp=0011010 trk=1", o, cur_track); end
        tick;
        play_done = 1'b1; tick; play_done = 1'b0;
        tick(4);
        checks++; if (o !== O_IDLE || preempt_cnt !== 8'd1) begin fails++; $display("FAIL nopre_end got=%b pc=%0d exp=%b pc=1", o, preempt_cnt, O_IDLE); end
    endtask

    task automatic test_timeout;
        req = 3'b001; tick; req = 3'b000; tick(2);
        tick(19);
        checks++; if (o !== 7'b1001_001 || timeout !== 1'b0) begin fails++; $display("FAIL wd_before got=%b to=%0b exp=1001001 to=0", o, timeout); end
        tick;
        checks++; if (o !== O_GAP || timeout !== 1'b1) begin fails++; $display("FAIL wd_fire got=%b to=%0b exp=%b to=1", o, timeout, O_GAP); end
        tick;
        checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL wd_pulse got=%0b exp=0", timeout); end
        tick(3);
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL wd_idle got=%b exp=%b", o, O_IDLE); end
    endtask

    task automatic test_mute_rst;
        req = 3'b100; tick; req = 3'b000; tick(2);
        req = 3'b011; tick; req = 3'b000;
        mute = 1'b1; tick;
        checks++; if (o !== O_GAP) begin fails++; $display("FAIL mute_gap got=%b exp=%b", o, O_GAP); end
        tick(4);
        mute = 1'b0; tick(5);
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL mute_flush got=%b exp=%b", o, O_IDLE); end
        req = 3'b001; tick; req = 3'b000; tick(2);
        checks++; if (o !== 7'b1001_001 || preempt_cnt !== 8'd1) begin fails++; $display("FAIL rst_pre got=%b pc=%0d exp=1001001 pc=1", o, preempt_cnt); end
        rst = 1'b1; tick; rst = 1'b0;
        checks++; if (o !== O_IDLE || {cur_track, preempt_cnt, timeout} !== 11'd0) begin fails++; $display("FAIL rst_mid got=%b trk=%0d pc=%0d exp=%b 0 0", o, cur_track, preempt_cnt, O_IDLE); end
        tick(4);
        checks++; if (o !== O_IDLE) begin fails++; $display("FAIL rst_stay got=%b exp=%b", o, O_IDLE); end
    endtask

    initial begin
        test_reset;
        tick(7);
        test_single;
        test_priority;
        test_preempt;
        test_no_preempt;
        test_timeout;
        test_mute_rst;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
